// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl
//   Entry/evaluate sequencer for the two-operand keypad calculator. One FSM
//   handles operand select, digit shift-in, add/sub mode and evaluation. The
//   result goes out as three BCD digits to the display scanner.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   key_vld   one-cycle strobe, key holds a newly pressed key
//   key       key code: 0-9 digits, 10-15 function keys (ignored here)
//   op_pls    switch operand A<->B (or chained edit from SHOW)
//   eq_pls    evaluate
//   mode_pls  toggle add/sub (entry states only)
//   clr_pls   clear operands and result, back to ENT_A (mode is kept)
//   mode      0 = add, 1 = sub
//   stage     FSM state: 0 ENT_A, 1 ENT_B, 2 CALC, 3 SHOW
//   done      one-cycle pulse in the first SHOW cycle
//   disp_d2   hundreds digit, or NEG_CODE for a negative difference
//   disp_d1   tens digit
//   disp_d0   ones digit
module calc_entry_ctrl #(
  parameter int         KEY_W    = 4,
  parameter logic [3:0] NEG_CODE = 4'd10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_vld,
  input  logic [KEY_W-1:0] key,
  input  logic             op_pls,
  input  logic             eq_pls,
  input  logic             mode_pls,
  input  logic             clr_pls,
  output logic             mode,
  output logic [1:0]       stage,
  output logic             done,
  output logic [3:0]       disp_d2,
  output logic [3:0]       disp_d1,
  output logic [3:0]       disp_d0
);

  typedef enum logic [1:0] {
    ENT_A = 2'd0,
    ENT_B = 2'd1,
    CALC  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] a_t, a_o, b_t, b_o;
  logic [3:0] hun, ten, one;
  logic       neg;
  logic [11:0] disp_q;

  logic       key_is_digit;
  logic [6:0] a_val, b_val, diff_val, rem_val;
  logic [7:0] sum_val, r_val;
  logic       r_neg, r_hun;

  assign key_is_digit = key_vld && (key <= KEY_W'(9));
  assign stage        = state;

  // Arithmetic for the CALC cycle: binary values of both operands, then the
  // sum or magnitude of the difference split back into BCD digits.
  always_comb begin
    a_val    = 7'(a_t) * 7'd10 + 7'(a_o);
    b_val    = 7'(b_t) * 7'd10 + 7'(b_o);
    sum_val  = 8'(a_val) + 8'(b_val);
    diff_val = (a_val >= b_val) ? (a_val - b_val) : (b_val - a_val);
    r_val    = mode ? {1'b0, diff_val} : sum_val;
    r_neg    = mode && (a_val < b_val);
    r_hun    = (r_val >= 8'd100);
    rem_val  = r_hun ? 7'(r_val - 8'd100) : r_val[6:0];
  end

  // Main sequencer. Events are taken in priority order clr > eq > op > mode
  // > key; only the winner acts. clr is honoured in every state, including
  // the CALC cycle, so a clear never leaves a half-finished result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ENT_A;
      a_t    <= 4'd0;
      a_o    <= 4'd0;
      b_t    <= 4'd0;
      b_o    <= 4'd0;
      hun    <= 4'd0;
      ten    <= 4'd0;
      one    <= 4'd0;
      neg    <= 1'b0;
      mode   <= 1'b0;
      done   <= 1'b0;
      disp_q <= 12'd0;
    end else begin
      done   <= 1'b0;
      // Copy of what is on the display now, shown again during CALC.
      disp_q <= {disp_d2, disp_d1, disp_d0};
      if (clr_pls) begin
        a_t   <= 4'd0;
        a_o   <= 4'd0;
        b_t   <= 4'd0;
        b_o   <= 4'd0;
        hun   <= 4'd0;
        ten   <= 4'd0;
        one   <= 4'd0;
        neg   <= 1'b0;
        state <= ENT_A;
      end else begin
        case (state)
          ENT_A, ENT_B: begin
            if (eq_pls) begin
              state <= CALC;
            end else if (op_pls) begin
              state <= (state == ENT_A) ? ENT_B : ENT_A;
            end else if (mode_pls) begin
              mode <= ~mode;
            end else if (key_is_digit) begin
              // Shift-left entry: old ones digit moves to tens.
              if (state == ENT_A) begin
                a_t <= a_o;
                a_o <= 4'(key);
              end else begin
                b_t <= b_o;
                b_o <= 4'(key);
              end
            end
          end
          CALC: begin
            hun   <= r_hun ? 4'd1 : 4'd0;
            ten   <= 4'(rem_val / 7'd10);
            one   <= 4'(rem_val % 7'd10);
            neg   <= r_neg;
            done  <= 1'b1;
            state <= SHOW;
          end
          SHOW: begin
            if (eq_pls) begin
              state <= CALC;
            end else if (op_pls) begin
              state <= ENT_B;
            end else if (!mode_pls && key_is_digit) begin
              // A fresh digit starts a new calculation from scratch.
              a_t   <= 4'd0;
              a_o   <= 4'(key);
              b_t   <= 4'd0;
              b_o   <= 4'd0;
              state <= ENT_A;
            end
          end
          default: state <= ENT_A;
        endcase
      end
    end
  end

  // Display mux from registered state.
  always_comb begin
    disp_d2 = 4'd0;
    disp_d1 = 4'd0;
    disp_d0 = 4'd0;
    case (state)
      ENT_A: begin
        disp_d1 = a_t;
        disp_d0 = a_o;
      end
      ENT_B: begin
        disp_d1 = b_t;
        disp_d0 = b_o;
      end
      CALC: begin
        disp_d2 = disp_q[11:8];
        disp_d1 = disp_q[7:4];
        disp_d0 = disp_q[3:0];
      end
      SHOW: begin
        disp_d2 = neg ? NEG_CODE : hun;
        disp_d1 = ten;
        disp_d0 = one;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl
//   Self-checking bench for calc_entry_ctrl. An integer-level model of the
//   calculator (operands and result held as plain numbers) is compared with
//   the DUT on every falling edge; directed scenarios add hand-computed
//   literal checks at key points.
module tb_calc_entry_ctrl;

  localparam int         KEY_W    = 4;
  localparam logic [3:0] NEG_CODE = 4'd10;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             key_vld  = 1'b0;
  logic [KEY_W-1:0] key      = '0;
  logic             op_pls   = 1'b0;
  logic             eq_pls   = 1'b0;
  logic             mode_pls = 1'b0;
  logic             clr_pls  = 1'b0;
  logic             mode;
  logic [1:0]       stage;
  logic             done;
  logic [3:0]       disp_d2, disp_d1, disp_d0;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model state: plain integers.
  int m_stage = 0;
  int m_a     = 0;
  int m_b     = 0;
  int m_r     = 0;
  int m_neg   = 0;
  int m_mode  = 0;
  int m_done  = 0;
  int m_saved = 0;

  calc_entry_ctrl #(.KEY_W(KEY_W), .NEG_CODE(NEG_CODE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_vld  (key_vld),
    .key      (key),
    .op_pls   (op_pls),
    .eq_pls   (eq_pls),
    .mode_pls (mode_pls),
    .clr_pls  (clr_pls),
    .mode     (mode),
    .stage    (stage),
    .done     (done),
    .disp_d2  (disp_d2),
    .disp_d1  (disp_d1),
    .disp_d0  (disp_d0)
  );

  always #5 clk = ~clk;

  // Expected display as d2*256 + d1*16 + d0 from the model state.
  function automatic int modelDisp();
    int d2, d1, d0;
    d2 = 0; d1 = 0; d0 = 0;
    case (m_stage)
      0: begin d1 = m_a / 10; d0 = m_a % 10; end
      1: begin d1 = m_b / 10; d0 = m_b % 10; end
      2: return m_saved;
      default: begin
        d2 = (m_neg != 0) ? int'(NEG_CODE) : m_r / 100;
        d1 = (m_r / 10) % 10;
        d0 = m_r % 10;
      end
    endcase
    return d2 * 256 + d1 * 16 + d0;
  endfunction

  // Calculator model, one step per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage = 0; m_a = 0; m_b = 0; m_r = 0; m_neg = 0;
      m_mode = 0; m_done = 0; m_saved = 0;
    end else begin
      m_saved = modelDisp();
      m_done  = (m_stage == 2 && !clr_pls) ? 1 : 0;
      if (clr_pls) begin
        m_a = 0; m_b = 0; m_r = 0; m_neg = 0; m_stage = 0;
      end else if (m_stage == 0 || m_stage == 1) begin
        if (eq_pls) m_stage = 2;
        else if (op_pls) m_stage = 1 - m_stage;
        else if (mode_pls) m_mode = 1 - m_mode;
        else if (key_vld && key <= 9) begin
          if (m_stage == 0) m_a = (m_a % 10) * 10 + int'(key);
          else              m_b = (m_b % 10) * 10 + int'(key);
        end
      end else if (m_stage == 2) begin
        if (m_mode == 0) begin
          m_r = m_a + m_b; m_neg = 0;
        end else begin
          m_r   = (m_a >= m_b) ? m_a - m_b : m_b - m_a;
          m_neg = (m_a < m_b) ? 1 : 0;
        end
        m_stage = 3;
      end else begin
        if (eq_pls) m_stage = 2;
        else if (op_pls) m_stage = 1;
        else if (mode_pls) ;
        else if (key_vld && key <= 9) begin
          m_a = int'(key); m_b = 0; m_stage = 0;
        end
      end
    end
  end

  task automatic checkVal(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkVal("cyc_stage", int'(stage), m_stage);
      checkVal("cyc_mode",  int'(mode),  m_mode);
      checkVal("cyc_done",  int'(done),  m_done);
      checkVal("cyc_disp",  int'({disp_d2, disp_d1, disp_d0}), modelDisp());
    end
  end

  // Called at posedge+1; holds the inputs for exactly one sampling edge.
  task automatic applyStimulus(input bit kv, input int k, input bit op,
                               input bit eq, input bit md, input bit clr);
    key_vld  = kv;
    key      = KEY_W'(k);
    op_pls   = op;
    eq_pls   = eq;
    mode_pls = md;
    clr_pls  = clr;
    @(posedge clk); #1;
    key_vld  = 1'b0;
    key      = '0;
    op_pls   = 1'b0;
    eq_pls   = 1'b0;
    mode_pls = 1'b0;
    clr_pls  = 1'b0;
  endtask

  task automatic pressKey(input int k);
    applyStimulus(1'b1, k, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Literal check on the falling edge, then one idle cycle.
  task automatic checkOutput(input string name, input int st, input int dn,
                             input int md, input int d2, input int d1, input int d0);
    @(negedge clk);
    checkVal({name, "_stage"}, int'(stage),   st);
    checkVal({name, "_done"},  int'(done),    dn);
    checkVal({name, "_mode"},  int'(mode),    md);
    checkVal({name, "_d2"},    int'(disp_d2), d2);
    checkVal({name, "_d1"},    int'(disp_d1), d1);
    checkVal({name, "_d0"},    int'(disp_d0), d0);
    @(posedge clk); #1;
  endtask

  initial begin
    cmp_en = 1'b1;
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // 47 + 25 = 72
    pressKey(4); pressKey(7);
    checkOutput("t1_a", 0, 0, 0, 0, 4, 7);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    pressKey(2); pressKey(5);
    checkOutput("t1_b", 1, 0, 0, 0, 2, 5);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_calc", 2, 0, 0, 0, 2, 5);
    checkOutput("t1_show", 3, 1, 0, 0, 7, 2);
    checkOutput("t1_hold", 3, 0, 0, 0, 7, 2);

    // sub: |12 - 45| = 33, negative
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    pressKey(1); pressKey(2);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    pressKey(4); pressKey(5);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_calc", 2, 0, 1, 0, 4, 5);
    checkOutput("t2_show", 3, 1, 1, 10, 3, 3);

    // 99 + 99 = 198, then re-evaluate
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    pressKey(9); pressKey(9);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    pressKey(9); pressKey(9);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_calc", 2, 0, 0, 0, 9, 9);
    checkOutput("t3_show", 3, 1, 0, 1, 9, 8);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_recalc", 2, 0, 0, 1, 9, 8);
    checkOutput("t3_reshow", 3, 1, 0, 1, 9, 8);

    // three digits shift out the first; key 11 ignored; mode ignored in SHOW
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    pressKey(1); pressKey(2); pressKey(3);
    checkOutput("t4_a", 0, 0, 0, 0, 2, 3);
    pressKey(11);
    checkOutput("t4_k11", 0, 0, 0, 0, 2, 3);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_calc", 2, 0, 0, 0, 2, 3);
    checkOutput("t4_show", 3, 1, 0, 0, 2, 3);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_mode", 3, 0, 0, 0, 2, 3);

    // chained edit, clr beats eq, op beats key
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    pressKey(5);
    checkOutput("t5_b", 1, 0, 0, 0, 0, 5);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_clr", 0, 0, 0, 0, 0, 0);
    pressKey(3);
    applyStimulus(1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_opkey", 1, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_a", 0, 0, 0, 0, 0, 3);

    // reset during CALC, then digit from SHOW starts over
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    pressKey(8);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    checkOutput("t6_rst", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    pressKey(6);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    pressKey(2);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_calc", 2, 0, 0, 0, 0, 2);
    checkOutput("t6_show", 3, 1, 0, 0, 0, 8);
    pressKey(4);
    checkOutput("t6_digit", 0, 0, 0, 0, 0, 4);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_b", 1, 0, 0, 0, 0, 0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
